// File: rtl/cube_move_scheduler.sv
// Cube-face turn sequencer: accepts one move at a time and drives step/dir for
// the selected stepper with fixed dir-setup, step period and post-move settle.
module cube_move_scheduler #(
  parameter int unsigned TICK_DIV     = 62500,
  parameter int unsigned PULSE_CYCLES = 250,
  parameter int unsigned STEPS_90     = 50,
  parameter int unsigned SETTLE_TICKS = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_face,
  input  logic [1:0] cmd_turn,
  input  logic       abort,
  output logic [5:0] step,
  output logic [5:0] dir,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned CYC_W      = $clog2(TICK_DIV);
  localparam int unsigned SET_W      = $clog2(SETTLE_TICKS * TICK_DIV);
  localparam int unsigned STP_W      = $clog2(2 * STEPS_90 + 1);
  localparam int unsigned SETTLE_MAX = SETTLE_TICKS * TICK_DIV - 1;

  typedef enum logic [2:0] {IDLE, SETUP, STEP_HI, STEP_LO, SETTLE} state_t;

  state_t           state, state_next;
  logic [CYC_W-1:0] cyc, cyc_next;
  logic [SET_W-1:0] settle_cnt, settle_next;
  logic [STP_W-1:0] steps_left, steps_next;
  logic [2:0]       face, face_next;
  logic [5:0]       step_next, dir_next;
  logic             busy_next, done_next, err_next;

  assign cmd_ready = (state == IDLE);

  // State and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cyc        <= '0;
      settle_cnt <= '0;
      steps_left <= '0;
      face       <= '0;
      step       <= '0;
      dir        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_next;
      cyc        <= cyc_next;
      settle_cnt <= settle_next;
      steps_left <= steps_next;
      face       <= face_next;
      step       <= step_next;
      dir        <= dir_next;
      busy       <= busy_next;
      done       <= done_next;
      err        <= err_next;
    end
  end

  // Next-state and next-output logic; cyc spans STEP_HI+STEP_LO as one period
  always_comb begin
    state_next  = state;
    cyc_next    = cyc;
    settle_next = settle_cnt;
    steps_next  = steps_left;
    face_next   = face;
    dir_next    = dir;
    done_next   = 1'b0;
    err_next    = 1'b0;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_face > 3'd5 || cmd_turn == 2'd3) begin
            err_next = 1'b1;
          end else begin
            face_next           = cmd_face;
            dir_next[cmd_face]  = (cmd_turn != 2'd1);
            steps_next          = (cmd_turn == 2'd2) ? STP_W'(2 * STEPS_90)
                                                     : STP_W'(STEPS_90);
            cyc_next            = '0;
            state_next          = SETUP;
          end
        end
      end
      SETUP: begin
        if (cyc == CYC_W'(PULSE_CYCLES - 1)) begin
          cyc_next   = '0;
          state_next = STEP_HI;
        end else begin
          cyc_next = cyc + CYC_W'(1);
        end
      end
      STEP_HI: begin
        cyc_next = cyc + CYC_W'(1);
        if (cyc == CYC_W'(PULSE_CYCLES - 1)) state_next = STEP_LO;
      end
      STEP_LO: begin
        if (cyc == CYC_W'(TICK_DIV - 1)) begin
          cyc_next = '0;
          if (steps_left == STP_W'(1)) begin
            settle_next = '0;
            state_next  = SETTLE;
          end else begin
            steps_next = steps_left - STP_W'(1);
            state_next = STEP_HI;
          end
        end else begin
          cyc_next = cyc + CYC_W'(1);
        end
      end
      SETTLE: begin
        if (settle_cnt == SET_W'(SETTLE_MAX)) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          settle_next = settle_cnt + SET_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    // Abort wins over normal completion and suppresses done
    if (abort && state != IDLE) begin
      state_next = IDLE;
      done_next  = 1'b0;
    end

    step_next = (state_next == STEP_HI) ? (6'(1) << face_next) : 6'd0;
    busy_next = (state_next != IDLE);
  end

endmodule
